// File: rtl/muldiv_pkg.sv
// Shared decode constants and enums for the EX-stage RV32M multiply/divide engine.
package muldiv_pkg;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
  localparam logic [2:0] F3_MUL        = 3'b000;
  localparam logic [2:0] F3_DIV        = 3'b100;
  localparam logic [2:0] F3_DIVU       = 3'b101;
  localparam logic [2:0] F3_REM        = 3'b110;
  localparam logic [2:0] F3_REMU       = 3'b111;
  localparam logic [1:0] ALUOP_RTYPE   = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} stateE;

  // DIV and DIVU share OP_DIV (likewise REM/REMU); signedness is tracked separately.
  typedef enum logic [1:0] {OP_MUL, OP_DIV, OP_REM} opE;

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// ID/EX-to-muldiv connection: decoded operation and operands in, stall/status/result out.
interface ex_muldiv_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic [1:0]      aluOp;
  logic [9:0]      funct;
  logic [XLEN-1:0] rsData;
  logic [XLEN-1:0] rtData;
  logic            stall;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  // Pipeline side: presents the ID/EX instruction, consumes stall and result.
  modport master (
    output aluOp, funct, rsData, rtData,
    input  stall, busy, done, result
  );

  // Engine side.
  modport slave (
    input  aluOp, funct, rsData, rtData,
    output stall, busy, done, result
  );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: a shift-add step for MUL or a restoring
// subtract step for DIV/REM. Purely combinational; state lives in the caller.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  opE              op,
  input  logic [XLEN-1:0] acc,
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] mcand,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] accNext,
  output logic [XLEN-1:0] remNext,
  output logic [XLEN-1:0] quoNext,
  output logic [XLEN-1:0] mcandNext
);

  logic [XLEN:0] trial;
  logic [XLEN:0] diff;

  // MUL: quo holds the remaining multiplier bits, mcand the shifted multiplicand.
  // DIV/REM: quo shifts the dividend out at the top and quotient bits in at the bottom.
  always_comb begin
    accNext   = acc;
    remNext   = rem;
    quoNext   = quo;
    mcandNext = mcand;
    trial     = {rem, quo[XLEN-1]};
    diff      = trial - {1'b0, divisor};
    if (op == OP_MUL) begin
      accNext   = acc + (quo[0] ? mcand : '0);
      mcandNext = mcand << 1;
      quoNext   = quo >> 1;
    end else if (!diff[XLEN]) begin
      // No borrow: partial remainder covers the divisor.
      remNext = diff[XLEN-1:0];
      quoNext = {quo[XLEN-2:0], 1'b1};
    end else begin
      remNext = trial[XLEN-1:0];
      quoNext = {quo[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide engine for the EX stage. Stalls the front of
// the pipeline while iterating and presents the result for a single DONE cycle.
// Optional build macro: MULDIV_FASTPATH_EN lets divide-by-zero, MUL by zero and
// signed overflow skip the iterations (IDLE -> DONE directly).
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  ex_muldiv_unit_if.slave    bus
);

  localparam int unsigned CntW = $clog2(XLEN) + 1;

  stateE           stateQ;
  logic [CntW-1:0] cntQ;
  opE              opQ;
  logic            negResQ;
  logic [XLEN-1:0] accQ, remQ, quoQ, mcandQ, divisorQ;
  logic            busyQ, doneQ;
  logic [XLEN-1:0] resultQ;

  logic            accept;
  opE              decOp;
  logic            decSigned;
  logic            aNeg, bNeg, bZero, decNegRes;
  logic [XLEN-1:0] aMag, bMag;
  logic            fastHit;
  logic [XLEN-1:0] fastRes;
  logic [XLEN-1:0] accNext, remNext, quoNext, mcandNext;
  logic [XLEN-1:0] rawRes, fixRes;

  // Decode the ID/EX instruction; MULH* and non-R-type ops are not accepted.
  always_comb begin
    accept    = 1'b0;
    decOp     = OP_MUL;
    decSigned = 1'b0;
    if (bus.aluOp == ALUOP_RTYPE && bus.funct[9:3] == FUNCT7_MULDIV) begin
      case (bus.funct[2:0])
        F3_MUL:  begin accept = 1'b1; decOp = OP_MUL; end
        F3_DIV:  begin accept = 1'b1; decOp = OP_DIV; decSigned = 1'b1; end
        F3_DIVU: begin accept = 1'b1; decOp = OP_DIV; end
        F3_REM:  begin accept = 1'b1; decOp = OP_REM; decSigned = 1'b1; end
        F3_REMU: begin accept = 1'b1; decOp = OP_REM; end
        default: accept = 1'b0;
      endcase
    end
  end

  // Operand magnitudes and the final sign fixup decided at accept time.
  // A zero divisor suppresses quotient negation so the quotient stays all ones.
  always_comb begin
    aNeg  = decSigned & bus.rsData[XLEN-1];
    bNeg  = decSigned & bus.rtData[XLEN-1];
    aMag  = aNeg ? -bus.rsData : bus.rsData;
    bMag  = bNeg ? -bus.rtData : bus.rtData;
    bZero = (bus.rtData == '0);
    case (decOp)
      OP_DIV:  decNegRes = (aNeg ^ bNeg) & ~bZero;
      OP_REM:  decNegRes = aNeg;
      default: decNegRes = 1'b0;
    endcase
  end

  // Early-out results for ops whose answer is known without iterating.
  always_comb begin
    fastHit = 1'b0;
    fastRes = '0;
`ifdef MULDIV_FASTPATH_EN
    if (decOp != OP_MUL && bZero) begin
      fastHit = 1'b1;
      fastRes = (decOp == OP_DIV) ? '1 : bus.rsData;
    end else if (decOp == OP_MUL && (bus.rsData == '0 || bZero)) begin
      fastHit = 1'b1;
      fastRes = '0;
    end else if (decSigned && bus.rsData == {1'b1, {(XLEN-1){1'b0}}} && bus.rtData == '1) begin
      fastHit = 1'b1;
      fastRes = (decOp == OP_DIV) ? bus.rsData : '0;
    end
`endif
  end

  muldiv_step #(
    .XLEN (XLEN)
  ) u_step (
    .op        (opQ),
    .acc       (accQ),
    .rem       (remQ),
    .quo       (quoQ),
    .mcand     (mcandQ),
    .divisor   (divisorQ),
    .accNext   (accNext),
    .remNext   (remNext),
    .quoNext   (quoNext),
    .mcandNext (mcandNext)
  );

  // Result of the final iteration, sign-corrected, captured on entry to DONE.
  always_comb begin
    case (opQ)
      OP_MUL:  rawRes = accNext;
      OP_DIV:  rawRes = quoNext;
      default: rawRes = remNext;
    endcase
    fixRes = negResQ ? -rawRes : rawRes;
  end

  // Control FSM, iteration counter, datapath registers and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stateQ   <= ST_IDLE;
      cntQ     <= '0;
      opQ      <= OP_MUL;
      negResQ  <= 1'b0;
      accQ     <= '0;
      remQ     <= '0;
      quoQ     <= '0;
      mcandQ   <= '0;
      divisorQ <= '0;
      busyQ    <= 1'b0;
      doneQ    <= 1'b0;
      resultQ  <= '0;
    end else begin
      unique case (stateQ)
        ST_IDLE: begin
          doneQ   <= 1'b0;
          resultQ <= '0;
          if (accept) begin
            if (fastHit) begin
              stateQ  <= ST_DONE;
              doneQ   <= 1'b1;
              resultQ <= fastRes;
            end else begin
              stateQ   <= ST_BUSY;
              busyQ    <= 1'b1;
              cntQ     <= '0;
              opQ      <= decOp;
              negResQ  <= decNegRes;
              accQ     <= '0;
              remQ     <= '0;
              // MUL runs on raw operands: the low word is sign-agnostic.
              quoQ     <= (decOp == OP_MUL) ? bus.rtData : aMag;
              mcandQ   <= (decOp == OP_MUL) ? bus.rsData : '0;
              divisorQ <= (decOp == OP_MUL) ? '0 : bMag;
            end
          end
        end
        ST_BUSY: begin
          accQ   <= accNext;
          remQ   <= remNext;
          quoQ   <= quoNext;
          mcandQ <= mcandNext;
          cntQ   <= cntQ + CntW'(1);
          if (cntQ == CntW'(XLEN - 1)) begin
            stateQ  <= ST_DONE;
            busyQ   <= 1'b0;
            doneQ   <= 1'b1;
            resultQ <= fixRes;
          end
        end
        ST_DONE: begin
          // ID/EX advances on this edge, so IDLE never sees this instruction again.
          stateQ  <= ST_IDLE;
          doneQ   <= 1'b0;
          resultQ <= '0;
        end
        default: stateQ <= ST_IDLE;
      endcase
    end
  end

  // Stall is raised combinationally in the accept cycle so ID/EX holds immediately.
  always_comb begin
    bus.stall  = ~rst_i & (((stateQ == ST_IDLE) & accept) | (stateQ == ST_BUSY));
    bus.busy   = busyQ;
    bus.done   = doneQ;
    bus.result = resultQ;
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit.
module tb_ex_muldiv_unit;
  import muldiv_pkg::*;

  localparam logic [9:0] FMUL  = {FUNCT7_MULDIV, F3_MUL};
  localparam logic [9:0] FDIV  = {FUNCT7_MULDIV, F3_DIV};
  localparam logic [9:0] FDIVU = {FUNCT7_MULDIV, F3_DIVU};
  localparam logic [9:0] FREM  = {FUNCT7_MULDIV, F3_REM};
  localparam logic [9:0] FREMU = {FUNCT7_MULDIV, F3_REMU};

`ifdef MULDIV_FASTPATH_EN
  localparam int FastStall = 1;
  localparam int FastLat   = 1;
`else
  localparam int FastStall = 33;
  localparam int FastLat   = 33;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ex_muldiv_unit_if #(.XLEN(32)) bus ();

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Applies an op just after a rising edge, holds it until DONE, samples on falling edges.
  // latency is the number of cycles after the accept cycle; -1 means DONE never came.
  task automatic run_op(input logic [9:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int stallCnt, output int busyCnt, output int latency,
                        output logic [31:0] res, output bit leak);
    @(posedge clk); #1;
    bus.aluOp  = ALUOP_RTYPE;
    bus.funct  = f;
    bus.rsData = a;
    bus.rtData = b;
    stallCnt = 0;
    busyCnt  = 0;
    latency  = -1;
    res      = 'x;
    leak     = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.stall === 1'b1) stallCnt++;
      if (bus.busy === 1'b1) busyCnt++;
      if (bus.done === 1'b1) begin
        latency = i;
        res     = bus.result;
        break;
      end
      if (bus.result !== 32'h0) leak = 1'b1;
    end
  endtask

  task automatic bubble();
    @(posedge clk); #1;
    bus.aluOp  = 2'b00;
    bus.funct  = 10'h0;
    bus.rsData = 32'h0;
    bus.rtData = 32'h0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.aluOp  = 2'b00;
    bus.funct  = 10'h0;
    bus.rsData = 32'h0;
    bus.rtData = 32'h0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.stall, bus.busy, bus.done} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=000", {bus.stall, bus.busy, bus.done});
    end
    checks++;
    if (bus.result !== 32'h0) begin
      failures++;
      $display("FAIL reset_result got=%h exp=00000000", bus.result);
    end
    bus.aluOp = ALUOP_RTYPE;
    bus.funct = FMUL;
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_stall_forced got=%b exp=0", bus.stall);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.aluOp = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_mul();
    int st, bz, lat;
    logic [31:0] r;
    bit leak;
    run_op(FMUL, 32'd7, 32'hFFFFFFFD, st, bz, lat, r, leak);
    checks++;
    if (r !== 32'hFFFFFFEB) begin
      failures++; $display("FAIL mul_result got=%h exp=ffffffeb", r);
    end
    checks++;
    if (st !== 33) begin failures++; $display("FAIL mul_stall got=%0d exp=33", st); end
    checks++;
    if (bz !== 32) begin failures++; $display("FAIL mul_busy got=%0d exp=32", bz); end
    checks++;
    if (lat !== 33) begin failures++; $display("FAIL mul_latency got=%0d exp=33", lat); end
    checks++;
    if (leak !== 1'b0) begin failures++; $display("FAIL mul_result_leak got=1 exp=0"); end
    bubble();
    checks++;
    if ({bus.done, bus.stall} !== 2'b00 || bus.result !== 32'h0) begin
      failures++;
      $display("FAIL mul_done_pulse got=%b/%h exp=00/00000000", {bus.done, bus.stall}, bus.result);
    end
  endtask

  task automatic test_div_rem();
    logic [9:0]  fv [4];
    logic [31:0] av [4];
    logic [31:0] bv [4];
    logic [31:0] ev [4];
    int st, bz, lat;
    logic [31:0] r;
    bit leak;
    fv = '{FDIV, FREM, FREMU, FDIVU};
    av = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd7, 32'hFFFFFFF9};
    bv = '{32'd2, 32'd2, 32'd2, 32'd2};
    ev = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd1, 32'h7FFFFFFC};
    for (int i = 0; i < 4; i++) begin
      run_op(fv[i], av[i], bv[i], st, bz, lat, r, leak);
      checks++;
      if (r !== ev[i] || st !== 33 || lat !== 33) begin
        failures++;
        $display("FAIL divrem_%0d got=%h/%0d/%0d exp=%h/33/33", i, r, st, lat, ev[i]);
      end
      bubble();
    end
  endtask

  task automatic test_div_zero();
    logic [9:0]  fv [5];
    logic [31:0] av [5];
    logic [31:0] bv [5];
    logic [31:0] ev [5];
    int st, bz, lat;
    logic [31:0] r;
    bit leak;
    fv = '{FDIVU, FREM, FDIV, FREM, FMUL};
    av = '{32'd100, 32'd100, 32'hFFFFFFFB, 32'hFFFFFFFB, 32'd0};
    bv = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd12345};
    ev = '{32'hFFFFFFFF, 32'd100, 32'hFFFFFFFF, 32'hFFFFFFFB, 32'd0};
    for (int i = 0; i < 5; i++) begin
      run_op(fv[i], av[i], bv[i], st, bz, lat, r, leak);
      checks++;
      if (r !== ev[i] || st !== FastStall || lat !== FastLat) begin
        failures++;
        $display("FAIL divzero_%0d got=%h/%0d/%0d exp=%h/%0d/%0d",
                 i, r, st, lat, ev[i], FastStall, FastLat);
      end
      bubble();
    end
  endtask

  task automatic test_overflow();
    int st, bz, lat;
    logic [31:0] r;
    bit leak;
    run_op(FDIV, 32'h80000000, 32'hFFFFFFFF, st, bz, lat, r, leak);
    checks++;
    if (r !== 32'h80000000 || st !== FastStall) begin
      failures++;
      $display("FAIL ovf_div got=%h/%0d exp=80000000/%0d", r, st, FastStall);
    end
    bubble();
    run_op(FREM, 32'h80000000, 32'hFFFFFFFF, st, bz, lat, r, leak);
    checks++;
    if (r !== 32'h0 || st !== FastStall) begin
      failures++;
      $display("FAIL ovf_rem got=%h/%0d exp=00000000/%0d", r, st, FastStall);
    end
    bubble();
  endtask

  task automatic test_reset_mid();
    int st, bz, lat;
    logic [31:0] r;
    bit leak;
    @(posedge clk); #1;
    bus.aluOp  = ALUOP_RTYPE;
    bus.funct  = FMUL;
    bus.rsData = 32'd3;
    bus.rtData = 32'd4;
    repeat (11) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b1) begin failures++; $display("FAIL rstmid_busy_before got=%b exp=1", bus.busy); end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin failures++; $display("FAIL rstmid_stall_forced got=%b exp=0", bus.stall); end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.aluOp = 2'b00;
    @(negedge clk);
    checks++;
    if ({bus.stall, bus.busy, bus.done} !== 3'b000 || bus.result !== 32'h0) begin
      failures++;
      $display("FAIL rstmid_idle got=%b/%h exp=000/00000000", {bus.stall, bus.busy, bus.done}, bus.result);
    end
    run_op(FMUL, 32'd3, 32'd4, st, bz, lat, r, leak);
    checks++;
    if (r !== 32'd12 || st !== 33) begin
      failures++; $display("FAIL rstmid_rerun got=%h/%0d exp=0000000c/33", r, st);
    end
    bubble();
  endtask

  task automatic test_back_to_back();
    int st, bz, lat;
    logic [31:0] r;
    bit leak;
    run_op(FMUL, 32'd3, 32'd4, st, bz, lat, r, leak);
    checks++;
    if (r !== 32'd12 || st !== 33 || lat !== 33) begin
      failures++; $display("FAIL b2b_first got=%h/%0d/%0d exp=0000000c/33/33", r, st, lat);
    end
    run_op(FDIVU, 32'd9, 32'd3, st, bz, lat, r, leak);
    checks++;
    if (r !== 32'd3 || st !== 33 || lat !== 33) begin
      failures++; $display("FAIL b2b_second got=%h/%0d/%0d exp=00000003/33/33", r, st, lat);
    end
    bubble();
    checks++;
    if ({bus.stall, bus.busy, bus.done} !== 3'b000) begin
      failures++; $display("FAIL b2b_norelaunch got=%b exp=000", {bus.stall, bus.busy, bus.done});
    end
  endtask

  task automatic test_not_accepted();
    logic [1:0] alv [3];
    logic [9:0] fv [3];
    alv = '{ALUOP_RTYPE, ALUOP_RTYPE, 2'b00};
    fv  = '{10'b0000000_000, {FUNCT7_MULDIV, 3'b001}, FMUL};
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bus.aluOp  = alv[i];
      bus.funct  = fv[i];
      bus.rsData = 32'd5;
      bus.rtData = 32'd6;
      #1;
      checks++;
      if (bus.stall !== 1'b0) begin
        failures++; $display("FAIL noaccept_stall_%0d got=%b exp=0", i, bus.stall);
      end
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.done} !== 2'b00) begin
        failures++; $display("FAIL noaccept_state_%0d got=%b exp=00", i, {bus.busy, bus.done});
      end
    end
    bubble();
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div_rem();
    test_div_zero();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    test_not_accepted();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
